// File: rtl/debug_hex_display.sv
// Debug word viewer: shows one of four 16-bit core debug words in hex on four
// active-low seven-segment digits, with a debounced page button and a freeze snapshot.
module debug_hex_display #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REFRESH_CYCLES  = 5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [15:0] in4,
  input  logic        btn_next_n,
  input  logic        sw_freeze,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [3:0]  page_led,
  output logic        frozen
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYCLES - 1);

  logic            btn_meta, btn_sync, stable;
  logic            frz_meta;
  logic [DB_W-1:0] db_cnt;
  logic [1:0]      page;
  logic [15:0]     snap [4];
  logic [15:0]     live [4];
  logic [RF_W-1:0] rf_cnt;
  logic            load_pending;
  logic [15:0]     shown;
  logic [15:0]     source;
  logic            btn_accept, press, frz_edge, event_hit, tick;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    live[0]    = in1;
    live[1]    = in2;
    live[2]    = in3;
    live[3]    = in4;
    source     = frozen ? snap[page] : live[page];
    btn_accept = (btn_sync != stable) && (db_cnt == DB_LAST);
    press      = btn_accept && !btn_sync;
    frz_edge   = frz_meta != frozen;
    event_hit  = press || frz_edge;
    tick       = rf_cnt == RF_LAST;
  end

  assign page_led = 4'b0001 << page;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
      frz_meta <= 1'b0;
      frozen   <= 1'b0;
    end else begin
      btn_meta <= btn_next_n;
      btn_sync <= btn_meta;
      frz_meta <= sw_freeze;
      frozen   <= frz_meta;
    end
  end

  // Any mismatch that does not persist for DEBOUNCE_CYCLES synced cycles is discarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable <= 1'b1;
      db_cnt <= '0;
    end else if (btn_sync == stable) begin
      db_cnt <= '0;
    end else if (btn_accept) begin
      stable <= btn_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      page <= 2'd0;
    end else if (press) begin
      page <= page + 2'd1;
    end
  end

  // NOTE: the snapshot array is small and must read as zero after reset, so it is reset like any register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) snap[i] <= '0;
    end else if (frz_meta && !frozen) begin
      for (int i = 0; i < 4; i++) snap[i] <= live[i];
    end
  end

  // A page or freeze event restarts the refresh period and defers the load by
  // one edge, so the load always sees the post-event page and frozen values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_cnt       <= '0;
      load_pending <= 1'b0;
      shown        <= '0;
    end else begin
      load_pending <= event_hit;
      if (event_hit || tick) rf_cnt <= '0;
      else                   rf_cnt <= rf_cnt + 1'b1;
      if (load_pending || (tick && !frozen && !event_hit)) shown <= source;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hex0 <= 7'h40;
      hex1 <= 7'h40;
      hex2 <= 7'h40;
      hex3 <= 7'h40;
    end else begin
      hex0 <= seg7(shown[3:0]);
      hex1 <= seg7(shown[7:4]);
      hex2 <= seg7(shown[11:8]);
      hex3 <= seg7(shown[15:12]);
    end
  end

endmodule

// File: tb/tb_debug_hex_display.sv
// Self-checking bench for debug_hex_display with short debounce and refresh periods.
module tb_debug_hex_display;

  localparam int DB = 4;
  localparam int RF = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic        btn_next_n = 1'b1;
  logic        sw_freeze = 1'b0;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic [3:0]  page_led;
  logic        frozen;
  logic [27:0] hexw;

  int checks = 0;
  int failures = 0;
  int ec = 0;

  typedef struct packed {
    logic [15:0] value;
    logic [6:0]  h3, h2, h1, h0;
  } vec_t;

  vec_t vecs [5];
  vec_t sb_q [$];

  debug_hex_display #(.DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RF)) dut (
    .clock(clock), .reset(reset),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .btn_next_n(btn_next_n), .sw_freeze(sw_freeze),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .page_led(page_led), .frozen(frozen)
  );

  always #5 clock = ~clock;
  assign hexw = {hex3, hex2, hex1, hex0};

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [27:0] segs(input logic [15:0] w);
    return {seg7(w[15:12]), seg7(w[11:8]), seg7(w[7:4]), seg7(w[3:0])};
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s @edge %0d: actual=%0h required=%0h", name, ec, actual, expected);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1ns after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      ec++;
      #1;
    end
  endtask

  task automatic press_release();
    btn_next_n = 1'b0;
    step(8);
    btn_next_n = 1'b1;
    step(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [27:0] prev_word;
    vec_t        exp_v;
    int          prev_change;
    int          changes;

    vecs[0] = '{16'h1234, 7'h79, 7'h24, 7'h30, 7'h19};
    vecs[1] = '{16'hABCD, 7'h08, 7'h03, 7'h46, 7'h21};
    vecs[2] = '{16'h5678, 7'h12, 7'h02, 7'h78, 7'h00};
    vecs[3] = '{16'h9EF0, 7'h10, 7'h06, 7'h0E, 7'h40};
    vecs[4] = '{16'h0000, 7'h40, 7'h40, 7'h40, 7'h40};

    step(2);
    check("por_hex", hexw, {4{7'h40}});
    check("por_page_led", page_led, 4'b0001);
    check("por_frozen", frozen, 1'b0);
    reset = 1'b0;
    ec = 0;

    // Live refresh: ticks land on edges 8, 16, ... after reset release.
    prev_word = {4{7'h40}};
    step(1);
    foreach (vecs[i]) begin
      in1 = vecs[i].value;
      sb_q.push_back(vecs[i]);
      step(7);
      check("refresh_hold", hexw, prev_word);
      step(1);
      exp_v = sb_q.pop_front();
      check("refresh_value", hexw, {exp_v.h3, exp_v.h2, exp_v.h1, exp_v.h0});
      prev_word = {exp_v.h3, exp_v.h2, exp_v.h1, exp_v.h0};
    end

    // Glitch of 3 cycles is rejected.
    in2 = 16'h2222;
    btn_next_n = 1'b0;
    step(3);
    btn_next_n = 1'b1;
    step(7);
    check("glitch_no_step", page_led, 4'b0001);

    // Accepted press: page steps 6 edges after the pin falls, hex follows 2 edges later.
    btn_next_n = 1'b0;
    step(5);
    check("press_not_yet", page_led, 4'b0001);
    step(1);
    check("press_page", page_led, 4'b0010);
    step(1);
    check("press_hex_pending", hexw, segs(16'h0000));
    step(1);
    check("press_hex_in2", hexw, segs(16'h2222));
    step(2);
    btn_next_n = 1'b1;
    step(7);
    press_release();
    check("page_2", page_led, 4'b0100);
    press_release();
    check("page_3", page_led, 4'b1000);
    press_release();
    check("page_wrap", page_led, 4'b0001);

    // Freeze browse.
    in1 = 16'h1111; in2 = 16'h2222; in3 = 16'h3333; in4 = 16'h4444;
    sw_freeze = 1'b1;
    step(1);
    check("freeze_sync_delay", frozen, 1'b0);
    step(1);
    check("freeze_on", frozen, 1'b1);
    in1 = '0; in2 = '0; in3 = '0; in4 = '0;
    step(2);
    check("freeze_snap_p0", hexw, segs(16'h1111));
    step(1);
    btn_next_n = 1'b0;
    step(6);
    check("freeze_press_page", page_led, 4'b0010);
    step(2);
    check("freeze_snap_p1", hexw, segs(16'h2222));
    btn_next_n = 1'b1;
    step(21);
    check("freeze_ticks_ignored", hexw, segs(16'h2222));
    sw_freeze = 1'b0;
    step(2);
    check("unfreeze", frozen, 1'b0);
    step(1);
    check("unfreeze_hex_hold", hexw, segs(16'h2222));
    step(1);
    check("unfreeze_live", hexw, segs(16'h0000));

    // Collision: press event lands on the tick at edge 168.
    in2 = 16'h5A5A;
    step(8);
    check("pre_collision_tick", hexw, segs(16'h5A5A));
    in2 = 16'h7777;
    in3 = 16'hC3C3;
    btn_next_n = 1'b0;
    step(6);
    check("collision_page", page_led, 4'b0100);
    step(1);
    check("collision_no_tick_load", hexw, segs(16'h5A5A));
    step(1);
    check("collision_single_load", hexw, segs(16'hC3C3));
    btn_next_n = 1'b1;
    in3 = 16'h0F0F;
    step(6);
    check("collision_next_tick_hold", hexw, segs(16'hC3C3));
    step(1);
    check("collision_next_tick", hexw, segs(16'h0F0F));

    // Wrap: in3 tracks the edge count; every display change must be 8 edges apart.
    prev_change = ec;
    prev_word = hexw;
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      in3 = 16'(ec);
      step(1);
      if (hexw !== prev_word) begin
        changes++;
        check("wrap_period", ec - prev_change, RF);
        check("wrap_value", hexw, segs(16'(ec - 2)));
        prev_change = ec;
        prev_word = hexw;
      end
    end
    check("wrap_count", changes, 12);

    // Asynchronous reset mid-operation, observed before the next edge.
    sw_freeze = 1'b1;
    step(3);
    check("pre_reset_frozen", frozen, 1'b1);
    reset = 1'b1;
    #1;
    check("reset_hex", hexw, {4{7'h40}});
    check("reset_page_led", page_led, 4'b0001);
    check("reset_frozen", frozen, 1'b0);
    step(1);
    reset = 1'b0;
    sw_freeze = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
